// File: rtl/id_imm_sequencer_pkg.sv
// Shared decode constants for the immediate-select sequencer.
// The optional IMM_ILLEGAL_EN macro adds illegal-opcode flagging.
package id_imm_sequencer_pkg;

  localparam int XLEN     = 32;
  localparam int SEL_W    = 4;
  localparam int SEL_ZEXT = 3;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_BLTU  = 3'b110;
  localparam logic [2:0] F3_BGEU  = 3'b111;

  typedef enum logic [2:0] {
    SEL_U  = 3'b000,
    SEL_J  = 3'b001,
    SEL_I  = 3'b010,
    SEL_B  = 3'b011,
    SEL_S  = 3'b100,
    SEL_SH = 3'b101
  } sel_fmt_e;

  function automatic logic [SEL_W-1:0] mk_code(input sel_fmt_e fmt, input logic zext);
    logic [SEL_W-1:0] c;
    c           = {SEL_W{1'b0}};
    c[2:0]      = fmt;
    c[SEL_ZEXT] = zext;
    return c;
  endfunction

endpackage

// File: rtl/id_imm_sequencer_imm_sel_decode.sv
// Combinational opcode/funct3 -> {has_imm, illegal, select code} decoder.
// illegal_o exists only when IMM_ILLEGAL_EN is defined.
module id_imm_sequencer_imm_sel_decode
  import id_imm_sequencer_pkg::*;
(
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
`ifdef IMM_ILLEGAL_EN
  output logic             illegal_o,
`endif
  output logic             has_imm_o,
  output logic [SEL_W-1:0] code_o
);

  // Opcode map; anything unlisted behaves as a no-immediate I-type slot.
  always_comb begin
    has_imm_o = 1'b1;
    code_o    = mk_code(SEL_I, 1'b0);
`ifdef IMM_ILLEGAL_EN
    illegal_o = 1'b0;
`endif
    case (opcode_i)
      OPC_LUI, OPC_AUIPC: code_o = mk_code(SEL_U, 1'b0);
      OPC_JAL:            code_o = mk_code(SEL_J, 1'b0);
      OPC_JALR, OPC_LOAD: code_o = mk_code(SEL_I, 1'b0);
      OPC_OP_IMM: begin
        case (funct3_i)
          F3_SLLI, F3_SRXI: code_o = mk_code(SEL_SH, 1'b0);
          F3_SLTIU:         code_o = mk_code(SEL_I, 1'b1);
          default:          code_o = mk_code(SEL_I, 1'b0);
        endcase
      end
      OPC_BRANCH: begin
        case (funct3_i)
          F3_BLTU, F3_BGEU: code_o = mk_code(SEL_B, 1'b1);
          default:          code_o = mk_code(SEL_B, 1'b0);
        endcase
      end
      OPC_STORE:          code_o = mk_code(SEL_S, 1'b0);
      OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: begin
        has_imm_o = 1'b0;
        code_o    = mk_code(SEL_I, 1'b0);
      end
      default: begin
        has_imm_o = 1'b0;
        code_o    = mk_code(SEL_I, 1'b0);
`ifdef IMM_ILLEGAL_EN
        illegal_o = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/id_imm_sequencer.sv
// Decode-stage sequencer: stage A drives the immediate generator, stage B captures its result.
// Define IMM_ILLEGAL_EN to flag unknown opcodes on out_illegal_o.
module id_imm_sequencer
  import id_imm_sequencer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_inst_i,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic             flush_i,
  output logic [31:0]      sel_inst_o,
  output logic [SEL_W-1:0] sel_code_o,
  input  logic [XLEN-1:0]  imm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_inst_o,
  output logic [XLEN-1:0]  out_pc_o,
  output logic [XLEN-1:0]  out_imm_o,
  output logic             out_has_imm_o
`ifdef IMM_ILLEGAL_EN
  , output logic           out_illegal_o
`endif
);

  localparam logic [SEL_W-1:0] SEL_RESET = 4'b0010;

  logic             a_valid_q, a_valid_d;
  logic [31:0]      a_inst_q, a_inst_d;
  logic [XLEN-1:0]  a_pc_q, a_pc_d;
  logic [SEL_W-1:0] a_code_q, a_code_d;
  logic             a_has_imm_q, a_has_imm_d;
  logic             b_valid_q, b_valid_d;
  logic [31:0]      b_inst_q, b_inst_d;
  logic [XLEN-1:0]  b_pc_q, b_pc_d;
  logic [XLEN-1:0]  b_imm_q, b_imm_d;
  logic             b_has_imm_q, b_has_imm_d;
  logic             dec_has_imm_s;
  logic [SEL_W-1:0] dec_code_s;
  logic             b_ready_s;
  logic             accept_s;
  logic             xfer_s;
`ifdef IMM_ILLEGAL_EN
  logic             dec_illegal_s;
  logic             a_illegal_q, a_illegal_d;
  logic             b_illegal_q, b_illegal_d;
`endif

  id_imm_sequencer_imm_sel_decode u_imm_sel_decode (
    .opcode_i  (in_inst_i[6:0]),
    .funct3_i  (in_inst_i[14:12]),
`ifdef IMM_ILLEGAL_EN
    .illegal_o (dec_illegal_s),
`endif
    .has_imm_o (dec_has_imm_s),
    .code_o    (dec_code_s)
  );

  assign b_ready_s  = ~b_valid_q | out_ready_i;
  assign in_ready_o = ~a_valid_q | b_ready_s;
  assign accept_s   = in_valid_i & in_ready_o;
  assign xfer_s     = a_valid_q & b_ready_s;

  // Stage A next state; flush beats a same-cycle accept and leaves the select held.
  always_comb begin
    a_valid_d   = a_valid_q;
    a_inst_d    = a_inst_q;
    a_pc_d      = a_pc_q;
    a_code_d    = a_code_q;
    a_has_imm_d = a_has_imm_q;
`ifdef IMM_ILLEGAL_EN
    a_illegal_d = a_illegal_q;
`endif
    if (flush_i) begin
      a_valid_d = 1'b0;
    end else if (accept_s) begin
      a_valid_d   = 1'b1;
      a_inst_d    = in_inst_i;
      a_pc_d      = in_pc_i;
      a_code_d    = dec_code_s;
      a_has_imm_d = dec_has_imm_s;
`ifdef IMM_ILLEGAL_EN
      a_illegal_d = dec_illegal_s;
`endif
    end else if (xfer_s) begin
      a_valid_d = 1'b0;
    end else begin
      a_valid_d = a_valid_q;
    end
  end

  // Stage B next state; the generator output is sampled while stage A still drives it.
  always_comb begin
    b_valid_d   = b_valid_q;
    b_inst_d    = b_inst_q;
    b_pc_d      = b_pc_q;
    b_imm_d     = b_imm_q;
    b_has_imm_d = b_has_imm_q;
`ifdef IMM_ILLEGAL_EN
    b_illegal_d = b_illegal_q;
`endif
    if (flush_i) begin
      b_valid_d = 1'b0;
    end else if (xfer_s) begin
      b_valid_d   = 1'b1;
      b_inst_d    = a_inst_q;
      b_pc_d      = a_pc_q;
      b_imm_d     = a_has_imm_q ? imm_i : {XLEN{1'b0}};
      b_has_imm_d = a_has_imm_q;
`ifdef IMM_ILLEGAL_EN
      b_illegal_d = a_illegal_q;
`endif
    end else if (out_ready_i) begin
      b_valid_d = 1'b0;
    end else begin
      b_valid_d = b_valid_q;
    end
  end

  // Stage A registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_valid_q   <= 1'b0;
      a_inst_q    <= 32'h0000_0000;
      a_pc_q      <= {XLEN{1'b0}};
      a_code_q    <= SEL_RESET;
      a_has_imm_q <= 1'b0;
`ifdef IMM_ILLEGAL_EN
      a_illegal_q <= 1'b0;
`endif
    end else begin
      a_valid_q   <= a_valid_d;
      a_inst_q    <= a_inst_d;
      a_pc_q      <= a_pc_d;
      a_code_q    <= a_code_d;
      a_has_imm_q <= a_has_imm_d;
`ifdef IMM_ILLEGAL_EN
      a_illegal_q <= a_illegal_d;
`endif
    end
  end

  // Stage B registers feeding ID/EX.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_valid_q   <= 1'b0;
      b_inst_q    <= 32'h0000_0000;
      b_pc_q      <= {XLEN{1'b0}};
      b_imm_q     <= {XLEN{1'b0}};
      b_has_imm_q <= 1'b0;
`ifdef IMM_ILLEGAL_EN
      b_illegal_q <= 1'b0;
`endif
    end else begin
      b_valid_q   <= b_valid_d;
      b_inst_q    <= b_inst_d;
      b_pc_q      <= b_pc_d;
      b_imm_q     <= b_imm_d;
      b_has_imm_q <= b_has_imm_d;
`ifdef IMM_ILLEGAL_EN
      b_illegal_q <= b_illegal_d;
`endif
    end
  end

  assign sel_inst_o    = a_inst_q;
  assign sel_code_o    = a_code_q;
  assign out_valid_o   = b_valid_q;
  assign out_inst_o    = b_inst_q;
  assign out_pc_o      = b_pc_q;
  assign out_imm_o     = b_imm_q;
  assign out_has_imm_o = b_has_imm_q;
`ifdef IMM_ILLEGAL_EN
  assign out_illegal_o = b_illegal_q;
`endif

endmodule

// File: tb/tb_id_imm_sequencer.sv
// Directed bench for id_imm_sequencer with a behavioural immediate generator.
// Checks out_illegal_o when IMM_ILLEGAL_EN is defined.
module tb_id_imm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic [31:0] sel_inst;
  logic [3:0]  sel_code;
  logic [31:0] imm_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic        out_has_imm;
`ifdef IMM_ILLEGAL_EN
  logic        out_illegal;
`endif

  int total = 0;
  int bad   = 0;

  // ADDI x1,x0,-1 / LUI x2,0x12345 / BLTU x1,x2,+16 / SW x2,8(x1) / SLLI x3,x1,5
  logic [31:0] s_inst [5] = '{32'hFFF0_0093, 32'h1234_5137, 32'h0020_E863, 32'h0020_A423, 32'h0050_9193};
  logic [3:0]  s_code [5] = '{4'b0010, 4'b0000, 4'b1011, 4'b0100, 4'b0101};
  logic [31:0] s_imm  [5] = '{32'hFFFF_FFFF, 32'h1234_5000, 32'h0000_0010, 32'h0000_0008, 32'h0000_0005};

  // ADD x3,x1,x2 / SLTIU x1,x0,-1 / JAL x0,+8 / opcode 1111111
  logic [31:0] m_inst [4] = '{32'h0020_81B3, 32'hFFF0_3093, 32'h0080_006F, 32'hFFFF_FFFF};
  logic [3:0]  m_code [4] = '{4'b0010, 4'b1010, 4'b0001, 4'b0010};
  logic        m_has  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] m_imm  [4] = '{32'h0000_0000, 32'h0000_0FFF, 32'h0000_0008, 32'h0000_0000};
  logic        m_ill  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input logic [3:0] c);
    logic [12:0] b13;
    logic [31:0] r;
    b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    case (c[2:0])
      3'b000:  r = {i[31:12], 12'h000};
      3'b001:  r = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      3'b010:  r = c[3] ? {20'h00000, i[31:20]} : {{20{i[31]}}, i[31:20]};
      3'b011:  r = c[3] ? {19'h00000, b13} : {{19{b13[12]}}, b13};
      3'b100:  r = {{20{i[31]}}, i[31:25], i[11:7]};
      3'b101:  r = {27'h0000000, i[24:20]};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  assign imm_in = gen_imm(sel_inst, sel_code);

  id_imm_sequencer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_inst_i     (in_inst),
    .in_pc_i       (in_pc),
    .flush_i       (flush),
    .sel_inst_o    (sel_inst),
    .sel_code_o    (sel_code),
    .imm_i         (imm_in),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_inst_o    (out_inst),
    .out_pc_o      (out_pc),
    .out_imm_o     (out_imm),
    .out_has_imm_o (out_has_imm)
`ifdef IMM_ILLEGAL_EN
    , .out_illegal_o (out_illegal)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (sel_code !== 4'b0010) begin bad++; $display("FAIL reset_sel_code got=%b want=0010", sel_code); end
    total++; if (sel_inst !== 32'h0 || out_inst !== 32'h0 || out_imm !== 32'h0 || out_pc !== 32'h0)
      begin bad++; $display("FAIL reset_data sel_inst=%h out_inst=%h out_imm=%h out_pc=%h want=0", sel_inst, out_inst, out_imm, out_pc); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        in_valid = 1'b1; in_inst = s_inst[i]; in_pc = 32'h0000_1000 + 32'(4 * i);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b want=1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i < 5) begin
        total++; if (sel_code !== s_code[i]) begin bad++; $display("FAIL stream_sel_code[%0d] got=%b want=%b", i, sel_code, s_code[i]); end
      end
      if (i >= 1) begin
        total++; if (out_valid !== 1'b1 || out_inst !== s_inst[i-1] || out_pc !== 32'h0000_1000 + 32'(4 * (i - 1)))
          begin bad++; $display("FAIL stream_out[%0d] valid=%b inst=%h pc=%h want inst=%h", i-1, out_valid, out_inst, out_pc, s_inst[i-1]); end
        total++; if (out_imm !== s_imm[i-1] || out_has_imm !== 1'b1)
          begin bad++; $display("FAIL stream_imm[%0d] got=%h has=%b want=%h", i-1, out_imm, out_has_imm, s_imm[i-1]); end
      end
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_stall;
    int acc;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_inst = s_inst[acc]; in_pc = 32'h0000_2000 + 32'(4 * acc);
      #1;
      if (in_ready) acc++;
      tick();
      if (c >= 2) begin
        total++; if (out_valid !== 1'b1 || out_inst !== s_inst[0] || out_imm !== s_imm[0] || sel_inst !== s_inst[1])
          begin bad++; $display("FAIL stall_hold[%0d] valid=%b out_inst=%h out_imm=%h sel_inst=%h", c, out_valid, out_inst, out_imm, sel_inst); end
      end
    end
    total++; if (acc !== 2) begin bad++; $display("FAIL stall_accepts got=%0d want=2", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b1 || out_inst !== s_inst[1] || out_imm !== s_imm[1] || out_pc !== 32'h0000_2004)
      begin bad++; $display("FAIL stall_drain valid=%b inst=%h imm=%h pc=%h want inst=%h", out_valid, out_inst, out_imm, out_pc, s_inst[1]); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = m_inst[2]; in_pc = 32'h0000_3000;
    tick();
    in_inst = s_inst[0]; in_pc = 32'h0000_3004; flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_setup_ready got=%b want=1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    total++; if (sel_inst !== m_inst[2] || out_inst !== s_inst[1])
      begin bad++; $display("FAIL flush_data_held sel_inst=%h out_inst=%h want %h %h", sel_inst, out_inst, m_inst[2], s_inst[1]); end
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost[%0d] got=%b want=0", k, out_valid); end
    end
  endtask

  task automatic test_misc_decode;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = m_inst[i]; in_pc = 32'h0000_4000;
      tick();
      in_valid = 1'b0;
      total++; if (sel_code !== m_code[i]) begin bad++; $display("FAIL misc_sel_code[%0d] got=%b want=%b", i, sel_code, m_code[i]); end
      tick();
      total++; if (out_valid !== 1'b1 || out_has_imm !== m_has[i] || out_imm !== m_imm[i])
        begin bad++; $display("FAIL misc_out[%0d] valid=%b has=%b imm=%h want has=%b imm=%h", i, out_valid, out_has_imm, out_imm, m_has[i], m_imm[i]); end
`ifdef IMM_ILLEGAL_EN
      total++; if (out_illegal !== m_ill[i]) begin bad++; $display("FAIL misc_illegal[%0d] got=%b want=%b", i, out_illegal, m_ill[i]); end
`else
      total++; if (m_ill[i] && out_has_imm !== 1'b0) begin bad++; $display("FAIL misc_unknown_noimm[%0d] got=%b want=0", i, out_has_imm); end
`endif
    end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = s_inst[0]; in_pc = 32'h0000_5000;
    tick();
    tick();
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
      begin bad++; $display("FAIL rstmid_setup valid=%b ready=%b want 1 0", out_valid, in_ready); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL rstmid_handshake valid=%b ready=%b want 0 1", out_valid, in_ready); end
    total++; if (sel_code !== 4'b0010 || sel_inst !== 32'h0)
      begin bad++; $display("FAIL rstmid_sel code=%b inst=%h want 0010 0", sel_code, sel_inst); end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_misc_decode();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
